// File: rtl/vt_wbmaster.sv
// vt_wbmaster: 2-entry command FIFO feeding single 16-bit Wishbone classic cycles.
// Optional feature macro WBM_TIMEOUT_EN: abort a cycle after TIMEOUT strobe cycles without ack.
module vt_wbmaster #(
    parameter int TIMEOUT = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [15:0] cmd_adr_i,
    input  logic [15:0] cmd_dat_i,
    input  logic [1:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic [15:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [1:0]  wb_sel_o,
    input  logic        wb_ack_i
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUS  = 1'b1;
    localparam int         ENTRY_W = 35;  // {we, adr, dat, sel}

    logic [0:0]         state;
    logic [ENTRY_W-1:0] fifo_mem [2];
    logic [1:0]         count;
    logic               wr_ptr;
    logic               rd_ptr;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic               tmo_hit;
    logic               bus_done;

    assign cmd_ready_o = (count != 2'd2);
    assign busy_o      = (count != 2'd0) | (state == ST_BUS);
    assign push        = cmd_valid_i & cmd_ready_o;
    assign pop         = (state == ST_IDLE) & (count != 2'd0);
    assign head        = fifo_mem[rd_ptr];
    assign bus_done    = (state == ST_BUS) & (wb_ack_i | tmo_hit);

    // NOTE: FIFO storage has no reset; count alone marks slots valid and reset clears count.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i};
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            // Push and pop together at count 1 leave count unchanged.
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state       <= ST_IDLE;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= 16'h0;
            wb_dat_o    <= 16'h0;
            wb_sel_o    <= 2'b00;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= 16'h0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Stray acks in IDLE are ignored; a cycle starts only from the FIFO.
                    if (pop) begin
                        {wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o} <= head;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        state    <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (bus_done) begin
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        // Writes and aborts (no ack) return zero data.
                        rsp_dat_o   <= (wb_we_o | ~wb_ack_i) ? 16'h0 : wb_dat_i;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef WBM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] tmo_cnt;
    logic       rsp_err_q;

    // Abort on the edge the count would reach TIMEOUT; an ack on that edge wins.
    assign tmo_hit   = (state == ST_BUS) & ~wb_ack_i & (tmo_cnt == TMO_LAST);
    assign rsp_err_o = rsp_err_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            tmo_cnt   <= 8'd0;
            rsp_err_q <= 1'b0;
        end else begin
            if (pop) begin
                tmo_cnt <= 8'd0;
            end else if ((state == ST_BUS) && !wb_ack_i) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
            if (bus_done) rsp_err_q <= tmo_hit;
        end
    end
`else
    // Without the timeout feature BUS waits for ack forever.
    if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_timeout_unused
    end
    assign tmo_hit   = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_vt_wbmaster.sv
// Self-checking bench for vt_wbmaster: directed vector table, multi-cycle sequences,
// and randomized traffic scored against an in-order register-file model.
module tb_vt_wbmaster;

    localparam int TMO = 16;
`ifdef WBM_TIMEOUT_EN
    localparam bit TMO_EN    = 1'b1;
    localparam int TMO_LIMIT = 100;
`else
    localparam bit TMO_EN    = 1'b0;
    localparam int TMO_LIMIT = 1000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_we;
    logic [15:0] cmd_adr, cmd_dat;
    logic [1:0]  cmd_sel;
    logic        cmd_ready_o, rsp_valid_o, rsp_err_o, busy_o;
    logic [15:0] rsp_dat_o;
    logic [15:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic [1:0]  wb_sel_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vt_wbmaster #(.TIMEOUT(TMO)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready_o),
        .cmd_we_i   (cmd_we),
        .cmd_adr_i  (cmd_adr),
        .cmd_dat_i  (cmd_dat),
        .cmd_sel_i  (cmd_sel),
        .rsp_valid_o(rsp_valid_o),
        .rsp_dat_o  (rsp_dat_o),
        .rsp_err_o  (rsp_err_o),
        .busy_o     (busy_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_ack_i   (wb_ack_i)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] init_val(input int i);
        return (i == 0) ? 16'hABCD : 16'(16'h1000 + i);
    endfunction

    // Register slave: 8 words decoded by adr[3:1], byte-lane writes, configurable ack.
    logic [15:0] regs [8];
    int          wait_cfg = 0;
    bit          no_ack = 1'b0;
    bit          comb_ack = 1'b0;
    int          wcnt;
    logic        ack_r;

    assign wb_ack_i = comb_ack ? (wb_cyc_o & wb_stb_o) : ack_r;
    assign wb_dat_i = regs[wb_adr_o[3:1]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r <= 1'b0;
            wcnt  <= 0;
            for (int i = 0; i < 8; i++) regs[i] <= init_val(i);
        end else begin
            if (wb_cyc_o && wb_stb_o && !ack_r && !no_ack && !comb_ack) begin
                if (wcnt >= wait_cfg) begin
                    ack_r <= 1'b1;
                    wcnt  <= 0;
                end else begin
                    wcnt <= wcnt + 1;
                end
            end else begin
                ack_r <= 1'b0;
                wcnt  <= 0;
            end
            if (wb_cyc_o && wb_stb_o && wb_ack_i && wb_we_o) begin
                if (wb_sel_o[0]) regs[wb_adr_o[3:1]][7:0]  <= wb_dat_o[7:0];
                if (wb_sel_o[1]) regs[wb_adr_o[3:1]][15:8] <= wb_dat_o[15:8];
            end
        end
    end

    // Reference model: commands complete strictly in acceptance order.
    typedef struct packed {
        logic [15:0] dat;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [15:0] mem [8];

    task automatic model_init();
        for (int i = 0; i < 8; i++) mem[i] = init_val(i);
    endtask

    task automatic model_push(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                              input logic [1:0] sel, input bit exp_err);
        int idx;
        idx = int'(adr[3:1]);
        if (exp_err) begin
            exp_q.push_back('{dat: 16'h0, err: 1'b1});
        end else if (we) begin
            if (sel[0]) mem[idx][7:0]  = dat[7:0];
            if (sel[1]) mem[idx][15:8] = dat[15:8];
            exp_q.push_back('{dat: 16'h0, err: 1'b0});
        end else begin
            exp_q.push_back('{dat: mem[idx], err: 1'b0});
        end
    endtask

    // Called at a negedge: presents a command for the next rising edge.
    task automatic drive_cmd(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                             input logic [1:0] sel, input bit exp_err, output bit accepted);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        accepted  = cmd_ready_o;
        if (accepted) model_push(we, adr, dat, sel, exp_err);
    endtask

    // Response scoreboard and bus-hold monitor.
    logic        prev_stb;
    logic [34:0] prev_bus;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stb <= 1'b0;
        end else begin
            if (prev_stb && wb_stb_o)
                check("bus_stable", {wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o}, prev_bus);
            if (rsp_valid_o) begin
                check("rsp_cyc_low", wb_cyc_o, 1'b0);
                if (exp_q.size() == 0) begin
                    check("stray_rsp", 1'b1, 1'b0);
                end else begin
                    check("rsp_dat", rsp_dat_o, exp_q[0].dat);
                    check("rsp_err", rsp_err_o, exp_q[0].err);
                    exp_q.delete(0);
                end
            end
            prev_stb <= wb_stb_o;
            prev_bus <= {wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o};
        end
    end

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [15:0] dat;
        logic [1:0]  sel;
        int          wait_n;
        bit          comb;
        logic [15:0] exp_dat;
        logic [15:0] exp_reg;
        int          exp_lat;
        int          exp_stb;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t v);
        int          stb_cnt;
        int          lat;
        bit          seen;
        bit          first;
        bit          acc;
        logic [15:0] dat;
        logic        err;
        stb_cnt  = 0;
        lat      = -1;
        seen     = 1'b0;
        first    = 1'b1;
        dat      = 16'h0;
        err      = 1'b0;
        wait_cfg = v.wait_n;
        comb_ack = v.comb;
        @(negedge clk);
        drive_cmd(v.we, v.adr, v.dat, v.sel, 1'b0, acc);
        check("vec_accept", acc, 1'b1);
        for (int t = 0; t <= 60 && !seen; t++) begin
            @(negedge clk);
            if (t == 0) cmd_valid = 1'b0;
            if (wb_stb_o) begin
                if (first) check("vec_bus", {wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o},
                                 {v.we, v.adr, v.dat, v.sel});
                first = 1'b0;
                stb_cnt++;
            end
            if (rsp_valid_o) begin
                seen = 1'b1;
                lat  = t;
                dat  = rsp_dat_o;
                err  = rsp_err_o;
            end
        end
        check("vec_latency", lat, v.exp_lat);
        check("vec_stb_cycles", stb_cnt, v.exp_stb);
        check("vec_rsp_dat", dat, v.exp_dat);
        check("vec_rsp_err", err, 1'b0);
        repeat (3) @(negedge clk);
        check("vec_slave_reg", regs[v.adr[3:1]], v.exp_reg);
        check("vec_idle", busy_o, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit acc;
        int n;
        int rt[3];
        int first_t;
        int stb_cnt;
        int sent;
        bit seen2;
        logic [15:0] got_dat;
        logic        got_err;

        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = 16'h0;
        cmd_dat   = 16'h0;
        cmd_sel   = 2'b00;
        model_init();

        //            we    adr       dat       sel    wt comb exp_dat   exp_reg   lat stb
        vecs[0] = '{1'b1, 16'h0002, 16'h0405, 2'b11, 0, 1'b0, 16'h0000, 16'h0405, 3, 2};
        vecs[1] = '{1'b0, 16'h0002, 16'h0000, 2'b11, 0, 1'b0, 16'h0405, 16'h0405, 3, 2};
        vecs[2] = '{1'b1, 16'h0000, 16'h1234, 2'b01, 0, 1'b0, 16'h0000, 16'hAB34, 3, 2};
        vecs[3] = '{1'b0, 16'h0000, 16'h0000, 2'b11, 0, 1'b0, 16'hAB34, 16'hAB34, 3, 2};
        vecs[4] = '{1'b1, 16'h0000, 16'h5678, 2'b10, 5, 1'b0, 16'h0000, 16'h5634, 8, 7};
        vecs[5] = '{1'b0, 16'h0000, 16'h0000, 2'b11, 5, 1'b0, 16'h5634, 16'h5634, 8, 7};
        vecs[6] = '{1'b0, 16'h0002, 16'h0000, 2'b11, 0, 1'b1, 16'h0405, 16'h0405, 2, 1};
        vecs[7] = '{1'b1, 16'h0004, 16'hBEEF, 2'b00, 0, 1'b0, 16'h0000, 16'h1002, 3, 2};
        vecs[8] = '{1'b0, 16'h0004, 16'h0000, 2'b11, 2, 1'b0, 16'h1002, 16'h1002, 5, 4};

        // Reset state, during and just after reset.
        repeat (3) @(negedge clk);
        check("rst_wb_outputs", {wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 0);
        check("rst_rsp", {rsp_valid_o, rsp_dat_o, rsp_err_o}, 0);
        check("rst_ready", cmd_ready_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {wb_cyc_o, wb_stb_o, busy_o, cmd_ready_o}, 4'b0001);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back: handshakes at E0, E1, E2; responses after E3, E6, E9.
        wait_cfg = 0;
        comb_ack = 1'b0;
        @(negedge clk);
        drive_cmd(1'b1, 16'h0006, 16'h00FF, 2'b11, 1'b0, acc);
        check("b2b_acc0", acc, 1'b1);
        @(negedge clk);
        drive_cmd(1'b0, 16'h0006, 16'h0000, 2'b11, 1'b0, acc);
        check("b2b_acc1", acc, 1'b1);
        @(negedge clk);
        drive_cmd(1'b0, 16'h0002, 16'h0000, 2'b11, 1'b0, acc);
        check("b2b_acc2", acc, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_full", cmd_ready_o, 1'b0);
        n = 0;
        rt[0] = -1; rt[1] = -1; rt[2] = -1;
        for (int t = 2; t <= 40 && n < 3; t++) begin
            if (t > 2) @(negedge clk);
            if (t == 3) check("b2b_still_full", cmd_ready_o, 1'b0);
            if (t == 4) check("b2b_ready_again", cmd_ready_o, 1'b1);
            if (rsp_valid_o) begin
                rt[n] = t;
                n++;
            end
        end
        check("b2b_rsp0_time", rt[0], 3);
        check("b2b_rsp1_time", rt[1], 6);
        check("b2b_rsp2_time", rt[2], 9);
        repeat (3) @(negedge clk);

        // Slave that never acks, with a second command queued behind it.
        no_ack = 1'b1;
        @(negedge clk);
        drive_cmd(1'b0, 16'h0002, 16'h0000, 2'b11, TMO_EN, acc);
        @(negedge clk);
        drive_cmd(1'b0, 16'h0000, 16'h0000, 2'b11, 1'b0, acc);
        check("tmo_second_accept", acc, 1'b1);
        first_t = -1;
        stb_cnt = 0;
        got_dat = 16'h0;
        got_err = 1'b0;
        for (int t = 1; t <= TMO_LIMIT && first_t < 0; t++) begin
            @(negedge clk);
            if (t == 1) cmd_valid = 1'b0;
            if (wb_stb_o) stb_cnt++;
            if (rsp_valid_o) begin
                first_t = t;
                got_dat = rsp_dat_o;
                got_err = rsp_err_o;
                no_ack  = 1'b0;
            end
        end
`ifdef WBM_TIMEOUT_EN
        check("tmo_latency", first_t, TMO + 1);
        check("tmo_stb_cycles", stb_cnt, TMO);
        check("tmo_err", got_err, 1'b1);
        check("tmo_dat", got_dat, 16'h0);
        seen2 = 1'b0;
        for (int t = 0; t < 20 && !seen2; t++) begin
            @(negedge clk);
            if (rsp_valid_o) seen2 = 1'b1;
        end
        check("tmo_next_rsp", seen2, 1'b1);
        repeat (3) @(negedge clk);
        // Set up a hung cycle with one entry queued for the reset test.
        no_ack = 1'b1;
        @(negedge clk);
        drive_cmd(1'b1, 16'h0002, 16'h7777, 2'b11, 1'b0, acc);
        @(negedge clk);
        drive_cmd(1'b0, 16'h0002, 16'h0000, 2'b11, 1'b0, acc);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
`else
        check("hang_no_rsp", first_t, -1);
        check("hang_stb_cycles", stb_cnt, TMO_LIMIT);
        check("hang_err_low", rsp_err_o, 1'b0);
`endif

        // Reset asserted mid-cycle with one entry still queued.
        check("pre_rst_stb", wb_stb_o, 1'b1);
        check("pre_rst_busy", busy_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_cyc_stb", {wb_cyc_o, wb_stb_o}, 2'b00);
        exp_q.delete();
        model_init();
        @(negedge clk);
        rst_n  = 1'b1;
        no_ack = 1'b0;
        check("rst_release_busy", busy_o, 1'b0);
        check("rst_release_ready", cmd_ready_o, 1'b1);
        n = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (rsp_valid_o || wb_cyc_o) n++;
        end
        check("rst_no_activity", n, 0);

        // Randomized traffic in batches with different slave speeds.
        for (int b = 0; b < 4; b++) begin
            wait_cfg = $urandom_range(0, 3);
            comb_ack = (b == 3);
            sent = 0;
            while (sent < 60) begin
                @(negedge clk);
                if ($urandom_range(0, 1) == 1) begin
                    drive_cmd(1'($urandom), 16'($urandom), 16'($urandom), 2'($urandom), 1'b0, acc);
                    if (acc) sent++;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            @(negedge clk);
            cmd_valid = 1'b0;
            for (int k = 0; k < 3000 && (exp_q.size() != 0 || busy_o); k++) @(negedge clk);
            repeat (2) @(negedge clk);
            check("rand_drain", exp_q.size(), 0);
            check("rand_idle", busy_o, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
